// File: rtl/correlator_tdm_if.sv
// Sample/slot input bus and daisy-chained visibility output bus of one correlator_tdm stage.
// The slave modport is the stage; the master modport is whoever feeds it and consumes its output.
interface correlator_tdm_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ABITS = 8,
    parameter int unsigned TRATE = 30,
    parameter int unsigned TBITS = (TRATE > 1) ? $clog2(TRATE) : 1
);
    logic             valid_i;
    logic             first_i;
    logic             last_i;
    logic [TBITS-1:0] taddr_i;
    logic [WIDTH-1:0] idata_i;
    logic [WIDTH-1:0] qdata_i;
    logic             prevs_i;
    logic [ABITS-1:0] revis_i;
    logic [ABITS-1:0] imvis_i;
    logic [ABITS-1:0] revis_o;
    logic [ABITS-1:0] imvis_o;
    logic             frame_o;
    logic             valid_o;
    logic             error_o;

    modport slave (
        input  valid_i, first_i, last_i, taddr_i, idata_i, qdata_i,
        input  prevs_i, revis_i, imvis_i,
        output revis_o, imvis_o, frame_o, valid_o, error_o
    );

    modport master (
        output valid_i, first_i, last_i, taddr_i, idata_i, qdata_i,
        output prevs_i, revis_i, imvis_i,
        input  revis_o, imvis_o, frame_o, valid_o, error_o
    );
endinterface

// File: rtl/correlator_tdm.sv
// Time-multiplexed 1-bit complex visibility correlator stage: S1 table lookup, S2 product/accumulator read,
// S3 accumulator write and chained output. Define CORRELATOR_SATURATE_EN for saturating accumulation.
module correlator_tdm #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ABITS = 8,
    parameter int unsigned TRATE = 30,
    parameter int unsigned SBITS = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    parameter int unsigned TBITS = (TRATE > 1) ? $clog2(TRATE) : 1,
    parameter logic [TRATE*SBITS-1:0] ATAB = '0,
    parameter logic [TRATE*SBITS-1:0] BTAB = '0,
    parameter logic [TRATE-1:0] AUTOS = '0
) (
    input logic             clock,
    input logic             reset,
    correlator_tdm_if.slave bus
);
    localparam logic [TBITS:0]   TRATE_W = TRATE[TBITS:0];
    localparam logic [ABITS-1:0] P1      = ABITS'(1);
    localparam logic [ABITS-1:0] M1      = '1;
`ifdef CORRELATOR_SATURATE_EN
    localparam logic [ABITS-1:0] MAX_V   = {1'b0, {(ABITS-1){1'b1}}};
    localparam logic [ABITS-1:0] MIN_V   = {1'b1, {(ABITS-1){1'b0}}};
`endif

    typedef struct packed {
        logic             valid;
        logic             first;
        logic             last;
        logic [TBITS-1:0] taddr;
        logic             ai;
        logic             aq;
        logic             bi;
        logic             bq;
        logic             is_auto;
    } s1_t;

    typedef struct packed {
        logic             valid;
        logic             first;
        logic             last;
        logic [TBITS-1:0] taddr;
        logic [ABITS-1:0] pre;
        logic [ABITS-1:0] pim;
        logic [ABITS-1:0] acc_re;
        logic [ABITS-1:0] acc_im;
    } s2_t;

    // Product of two +/-1 signs carried as bits (1 = +1, 0 = -1).
    function automatic logic [ABITS-1:0] sign_prod(input logic x, input logic y);
        return (x == y) ? P1 : M1;
    endfunction

    // Returns {saturated, sum} of two ABITS-wide two's-complement values.
    function automatic logic [ABITS:0] acc_add(input logic [ABITS-1:0] a, input logic [ABITS-1:0] b);
`ifdef CORRELATOR_SATURATE_EN
        logic [ABITS:0] wide;
        wide = {a[ABITS-1], a} + {b[ABITS-1], b};
        if (wide[ABITS] != wide[ABITS-1]) begin
            return {1'b1, wide[ABITS] ? MIN_V : MAX_V};
        end
        return {1'b0, wide[ABITS-1:0]};
`else
        return {1'b0, a + b};
`endif
    endfunction

    logic [SBITS-1:0] a_tab [TRATE];
    logic [SBITS-1:0] b_tab [TRATE];

    for (genvar t = 0; t < TRATE; t++) begin : g_tab
        assign a_tab[t] = ATAB[t*SBITS +: SBITS];
        assign b_tab[t] = BTAB[t*SBITS +: SBITS];
    end

    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;

    logic [ABITS-1:0] acc_re_mem [TRATE];
    logic [ABITS-1:0] acc_im_mem [TRATE];

    logic             in_range;
    logic [TBITS-1:0] lut_idx;
    logic [SBITS-1:0] a_sel;
    logic [SBITS-1:0] b_sel;

    logic [ABITS-1:0] base_re, base_im;
    logic [ABITS-1:0] sum_re, sum_im;
    logic             sat_re, sat_im;
    logic             emit;
    logic             fwd;

    logic [ABITS-1:0] revis_d, revis_q;
    logic [ABITS-1:0] imvis_d, imvis_q;
    logic             valid_d, valid_q;
    logic             frame_d, frame_q;
    logic             error_d, error_q;

    // S1: drop out-of-range slots and pick the A/B antenna bits for this slot.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        s1_d     = '0;
        in_range = ({1'b0, bus.taddr_i} < TRATE_W);
        lut_idx  = in_range ? bus.taddr_i : '0;
        a_sel    = a_tab[lut_idx];
        b_sel    = b_tab[lut_idx];

        s1_d.valid   = bus.valid_i && in_range;
        s1_d.first   = bus.first_i;
        s1_d.last    = bus.last_i;
        s1_d.taddr   = lut_idx;
        s1_d.ai      = bus.idata_i[a_sel];
        s1_d.aq      = bus.qdata_i[a_sel];
        s1_d.bi      = bus.idata_i[b_sel];
        s1_d.bq      = bus.qdata_i[b_sel];
        s1_d.is_auto = AUTOS[lut_idx];
    end

    // S2: product, plus accumulator read forwarded from S3 when S3 is writing the same slot this cycle.
    always_comb begin
        s2_d       = '0;
        s2_d.valid = s1_q.valid;
        s2_d.first = s1_q.first;
        s2_d.last  = s1_q.last;
        s2_d.taddr = s1_q.taddr;

        if (s1_q.is_auto) begin
            s2_d.pre = s1_q.ai ? P1 : M1;
            s2_d.pim = s1_q.aq ? P1 : M1;
        end else begin
            s2_d.pre = sign_prod(s1_q.ai, s1_q.bi) + sign_prod(s1_q.aq, s1_q.bq);
            s2_d.pim = sign_prod(s1_q.aq, s1_q.bi) - sign_prod(s1_q.ai, s1_q.bq);
        end

        fwd         = s2_q.valid && (s2_q.taddr == s1_q.taddr);
        s2_d.acc_re = fwd ? sum_re : acc_re_mem[s1_q.taddr];
        s2_d.acc_im = fwd ? sum_im : acc_im_mem[s1_q.taddr];
    end

    // S3: new accumulator value, and the output word (local emission has priority over upstream).
    always_comb begin
        base_re          = s2_q.first ? '0 : s2_q.acc_re;
        base_im          = s2_q.first ? '0 : s2_q.acc_im;
        {sat_re, sum_re} = acc_add(base_re, s2_q.pre);
        {sat_im, sum_im} = acc_add(base_im, s2_q.pim);

        emit    = s2_q.valid && s2_q.last;
        valid_d = emit || bus.prevs_i;
        revis_d = emit ? sum_re : bus.revis_i;
        imvis_d = emit ? sum_im : bus.imvis_i;
        frame_d = emit && (s2_q.taddr == '0);
        error_d = error_q || (emit && bus.prevs_i);
`ifdef CORRELATOR_SATURATE_EN
        error_d = error_d || (s2_q.valid && (sat_re || sat_im));
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q    <= '0;
            s2_q    <= '0;
            revis_q <= '0;
            imvis_q <= '0;
            valid_q <= 1'b0;
            frame_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            revis_q <= revis_d;
            imvis_q <= imvis_d;
            valid_q <= valid_d;
            frame_q <= frame_d;
            error_q <= error_d;
        end
    end

    // NOTE: the accumulator bank is not reset; every frame starts with first_i, which overwrites it.
    always_ff @(posedge clock) begin
        if (!reset && s2_q.valid) begin
            acc_re_mem[s2_q.taddr] <= sum_re;
            acc_im_mem[s2_q.taddr] <= sum_im;
        end
    end

    assign bus.revis_o = revis_q;
    assign bus.imvis_o = imvis_q;
    assign bus.valid_o = valid_q;
    assign bus.frame_o = frame_q;
    assign bus.error_o = error_q;
endmodule

// File: tb/tb_correlator_tdm.sv
// Self-checking bench for correlator_tdm: an 8-bit and a 4-bit accumulator instance share one stimulus,
// compared every cycle against an integer reference model plus directed constant checks.
`timescale 1ns/1ps
module tb_correlator_tdm;
    localparam int WIDTH = 4;
    localparam int TRATE = 3;
    localparam int ABITS = 8;
    localparam int NBITS = 4;
    // slot 0: A=ant0 B=ant3, slot 1: A=ant1 B=ant2, slot 2: auto on ant1
    localparam logic [5:0] ATAB_P  = {2'd1, 2'd1, 2'd0};
    localparam logic [5:0] BTAB_P  = {2'd0, 2'd2, 2'd3};
    localparam logic [2:0] AUTOS_P = 3'b100;

    int a_ant   [TRATE] = '{0, 1, 1};
    int b_ant   [TRATE] = '{3, 2, 0};
    bit is_auto [TRATE] = '{0, 0, 1};
    int bits_of [2]     = '{ABITS, NBITS};

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    correlator_tdm_if #(.WIDTH(WIDTH), .ABITS(ABITS), .TRATE(TRATE)) m_if ();
    correlator_tdm_if #(.WIDTH(WIDTH), .ABITS(NBITS), .TRATE(TRATE)) n_if ();

    assign n_if.valid_i = m_if.valid_i;
    assign n_if.first_i = m_if.first_i;
    assign n_if.last_i  = m_if.last_i;
    assign n_if.taddr_i = m_if.taddr_i;
    assign n_if.idata_i = m_if.idata_i;
    assign n_if.qdata_i = m_if.qdata_i;
    assign n_if.prevs_i = 1'b0;
    assign n_if.revis_i = '0;
    assign n_if.imvis_i = '0;

    correlator_tdm #(
        .WIDTH(WIDTH), .ABITS(ABITS), .TRATE(TRATE),
        .ATAB(ATAB_P), .BTAB(BTAB_P), .AUTOS(AUTOS_P)
    ) u_main (
        .clock(clk),
        .reset(rst),
        .bus(m_if.slave)
    );

    correlator_tdm #(
        .WIDTH(WIDTH), .ABITS(NBITS), .TRATE(TRATE),
        .ATAB(ATAB_P), .BTAB(BTAB_P), .AUTOS(AUTOS_P)
    ) u_narrow (
        .clock(clk),
        .reset(rst),
        .bus(n_if.slave)
    );

    typedef struct packed {
        bit vld;
        bit frm;
        int re;
        int im;
    } word_t;

    // Reference model: integer accumulators per instance/slot, and a small ring of scheduled output events.
    int    acc_re [2][TRATE];
    int    acc_im [2][TRATE];
    bit    inited [TRATE];
    word_t loc    [2][8];
    bit    loc_v  [2][8];
    bit    sat_ev [2][8];
    bit    err_m  [2];
    word_t exp_w  [2];

    task automatic check(input string tag, input int obs, input int expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int acc_upd(input int acc, input int p, input int bits, output bit sat);
        int s, lo, hi, span;
        span = 1 << bits;
        hi   = span / 2 - 1;
        lo   = -(span / 2);
        s    = acc + p;
        sat  = 1'b0;
`ifdef CORRELATOR_SATURATE_EN
        if (s > hi) begin s = hi; sat = 1'b1; end
        else if (s < lo) begin s = lo; sat = 1'b1; end
`else
        if (s > hi) s -= span;
        else if (s < lo) s += span;
`endif
        return s;
    endfunction

    function automatic int sgn(input logic b);
        return b ? 1 : -1;
    endfunction

    task automatic model_apply();
        int k0, k1, k2, slot, pr, pi, ai, aq, bi, bq;
        bit sr, si;
        k0 = cyc % 8;
        k1 = (cyc + 1) % 8;
        k2 = (cyc + 2) % 8;
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                err_m[i]      = 1'b0;
                exp_w[i]      = '0;
                loc_v[i][k0]  = 1'b0;
                loc_v[i][k1]  = 1'b0;
                sat_ev[i][k0] = 1'b0;
                sat_ev[i][k1] = 1'b0;
            end
            for (int s = 0; s < TRATE; s++) inited[s] = 1'b0;
            return;
        end
        slot = int'(m_if.taddr_i);
        if (m_if.valid_i && slot < TRATE) begin
            ai = sgn(m_if.idata_i[a_ant[slot]]);
            aq = sgn(m_if.qdata_i[a_ant[slot]]);
            bi = sgn(m_if.idata_i[b_ant[slot]]);
            bq = sgn(m_if.qdata_i[b_ant[slot]]);
            if (is_auto[slot]) begin
                pr = ai;
                pi = aq;
            end else begin
                pr = ai * bi + aq * bq;
                pi = aq * bi - ai * bq;
            end
            for (int i = 0; i < 2; i++) begin
                if (m_if.first_i) begin
                    acc_re[i][slot] = pr;
                    acc_im[i][slot] = pi;
                end else begin
                    acc_re[i][slot] = acc_upd(acc_re[i][slot], pr, bits_of[i], sr);
                    acc_im[i][slot] = acc_upd(acc_im[i][slot], pi, bits_of[i], si);
                    if (sr || si) sat_ev[i][k2] = 1'b1;
                end
                if (m_if.last_i) begin
                    loc[i][k2]   = '{vld: 1'b1, frm: (slot == 0), re: acc_re[i][slot], im: acc_im[i][slot]};
                    loc_v[i][k2] = 1'b1;
                end
            end
            inited[slot] = 1'b1;
        end
        for (int i = 0; i < 2; i++) begin
            if (loc_v[i][k0]) begin
                exp_w[i] = loc[i][k0];
                if (i == 0 && m_if.prevs_i) err_m[i] = 1'b1;
            end else if (i == 0) begin
                exp_w[i] = '{vld: m_if.prevs_i, frm: 1'b0,
                             re: int'($signed(m_if.revis_i)), im: int'($signed(m_if.imvis_i))};
            end else begin
                exp_w[i] = '0;
            end
            if (sat_ev[i][k0]) err_m[i] = 1'b1;
            loc_v[i][k0]  = 1'b0;
            sat_ev[i][k0] = 1'b0;
        end
    endtask

    task automatic check_all();
        string c;
        c = $sformatf("c%0d", cyc);
        check({c, " main valid_o"}, int'(m_if.valid_o), int'(exp_w[0].vld));
        check({c, " main frame_o"}, int'(m_if.frame_o), int'(exp_w[0].frm));
        check({c, " main error_o"}, int'(m_if.error_o), int'(err_m[0]));
        check({c, " main revis_o"}, int'($signed(m_if.revis_o)), exp_w[0].re);
        check({c, " main imvis_o"}, int'($signed(m_if.imvis_o)), exp_w[0].im);
        check({c, " narrow valid_o"}, int'(n_if.valid_o), int'(exp_w[1].vld));
        check({c, " narrow frame_o"}, int'(n_if.frame_o), int'(exp_w[1].frm));
        check({c, " narrow error_o"}, int'(n_if.error_o), int'(err_m[1]));
        check({c, " narrow revis_o"}, int'($signed(n_if.revis_o)), exp_w[1].re);
        check({c, " narrow imvis_o"}, int'($signed(n_if.imvis_o)), exp_w[1].im);
    endtask

    task automatic step();
        model_apply();
        @(posedge clk);
        #1;
        check_all();
        cyc++;
    endtask

    task automatic drive(input bit v, input bit f, input bit l, input int t,
                         input logic [3:0] id, input logic [3:0] qd);
        m_if.valid_i = v;
        m_if.first_i = f;
        m_if.last_i  = l;
        m_if.taddr_i = 2'(t);
        m_if.idata_i = id;
        m_if.qdata_i = qd;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 0, 4'h0, 4'h0);
        m_if.prevs_i = 1'b0;
        m_if.revis_i = '0;
        m_if.imvis_i = '0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        for (int i = 0; i < 2; i++) begin
            err_m[i] = 1'b0;
            exp_w[i] = '0;
            for (int k = 0; k < 8; k++) begin
                loc_v[i][k]  = 1'b0;
                sat_ev[i][k] = 1'b0;
            end
        end
        idle();
        rst = 1'b1;
        repeat (3) step();
        check("reset valid_o", int'(m_if.valid_o), 0);
        check("reset error_o", int'(m_if.error_o), 0);
        check("reset revis_o", int'(m_if.revis_o), 0);
        rst = 1'b0;
        step();

        // Slot 0, ant0 = ant3 = (1,1): five samples of +2 each.
        for (int n = 0; n < 5; n++) begin
            drive(1'b1, n == 0, n == 4, 0, 4'b1001, 4'b1001);
            step();
        end
        idle();
        step();
        step();
        check("frame5 re", int'($signed(m_if.revis_o)), 10);
        check("frame5 im", int'($signed(m_if.imvis_o)), 0);
        check("frame5 frame_o", int'(m_if.frame_o), 1);
        check("frame5 valid_o", int'(m_if.valid_o), 1);
`ifdef CORRELATOR_SATURATE_EN
        check("narrow saturate re", int'($signed(n_if.revis_o)), 7);
        check("narrow saturate error_o", int'(n_if.error_o), 1);
`else
        check("narrow wrap re", int'($signed(n_if.revis_o)), -6);
        check("narrow wrap error_o", int'(n_if.error_o), 0);
`endif

        // Slot 1, ant1 = (i1,q0), ant2 = (i0,q1): single-sample frame.
        drive(1'b1, 1'b1, 1'b1, 1, 4'b0010, 4'b0100);
        step();
        idle();
        step();
        step();
        check("single re", int'($signed(m_if.revis_o)), -2);
        check("single im", int'($signed(m_if.imvis_o)), 0);
        check("single frame_o", int'(m_if.frame_o), 0);
        check("single valid_o", int'(m_if.valid_o), 1);
        step();
        check("single valid_o drop", int'(m_if.valid_o), 0);

        // Auto slot 2 on ant1 = (1,0) for three samples.
        for (int n = 0; n < 3; n++) begin
            drive(1'b1, n == 0, n == 2, 2, 4'b0010, 4'b0000);
            step();
        end
        idle();
        step();
        step();
        check("auto re", int'($signed(m_if.revis_o)), 3);
        check("auto im", int'($signed(m_if.imvis_o)), -3);

        // Idle stage passes the upstream word through.
        m_if.prevs_i = 1'b1;
        m_if.revis_i = 8'h12;
        m_if.imvis_i = 8'hF0;
        step();
        check("pass valid_o", int'(m_if.valid_o), 1);
        check("pass revis_o", int'(m_if.revis_o), 'h12);
        check("pass imvis_o", int'(m_if.imvis_o), 'hF0);
        check("pass error_o", int'(m_if.error_o), 0);
        idle();

        // Local emission collides with upstream word.
        drive(1'b1, 1'b1, 1'b1, 0, 4'b1001, 4'b1001);
        step();
        idle();
        step();
        m_if.prevs_i = 1'b1;
        m_if.revis_i = 8'h55;
        m_if.imvis_i = 8'h66;
        step();
        check("collide re", int'($signed(m_if.revis_o)), 2);
        check("collide frame_o", int'(m_if.frame_o), 1);
        check("collide error_o", int'(m_if.error_o), 1);
        idle();
        repeat (3) step();
        check("collide error_o sticky", int'(m_if.error_o), 1);

        // Out-of-range slot is dropped.
        drive(1'b1, 1'b1, 1'b1, 3, 4'b1111, 4'b1111);
        step();
        idle();
        step();
        step();
        check("out of range valid_o", int'(m_if.valid_o), 0);

        // Reset right after a last sample, then a fresh two-sample frame on slot 0.
        drive(1'b1, 1'b1, 1'b0, 0, 4'b1001, 4'b1001);
        step();
        drive(1'b1, 1'b0, 1'b1, 0, 4'b1001, 4'b1001);
        step();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("reset error_o cleared", int'(m_if.error_o), 0);
        step();
        check("no stale emission", int'(m_if.valid_o), 0);
        drive(1'b1, 1'b1, 1'b0, 0, 4'b1000, 4'b1000);
        step();
        drive(1'b1, 1'b0, 1'b1, 0, 4'b1000, 4'b1000);
        step();
        idle();
        step();
        step();
        check("post reset re", int'($signed(m_if.revis_o)), -4);
        check("post reset im", int'($signed(m_if.imvis_o)), 0);

        // Random traffic, back-to-back slots, upstream words and occasional resets.
        for (int n = 0; n < 600; n++) begin
            int t;
            t = int'($urandom_range(0, 3));
            rst = ($urandom_range(0, 199) == 0);
            drive($urandom_range(0, 3) != 0,
                  ($urandom_range(0, 3) == 0) || (t < TRATE && !inited[t]),
                  $urandom_range(0, 2) == 0, t,
                  4'($urandom), 4'($urandom));
            m_if.prevs_i = ($urandom_range(0, 7) == 0);
            m_if.revis_i = 8'($urandom);
            m_if.imvis_i = 8'($urandom);
            step();
        end
        rst = 1'b0;
        idle();
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
